// File: rtl/uart_rx_unit.sv
// uart_rx_unit
//   Serial receive front end: deframes asynchronous 8N1 data from UART_RX
//   into bytes for the CPU peripheral bus. Uses 16x oversampling with a
//   3-sample majority vote at phases 7/8/9 of each bit. Each byte is presented
//   through a one-entry holding register with a valid/ready handshake.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, one even-parity bit is expected between the data bits and
//     the stop bit, and the rx_parity_err port exists.
//
// Ports:
//   clk           in   core clock, rising edge
//   reset         in   synchronous active-high reset
//   UART_RX       in   asynchronous serial line, idles high
//   rx_data       out  [7:0] holding-register byte
//   rx_valid      out  holding register full
//   rx_ready      in   consumer accepts the byte when rx_valid is also high
//   rx_overrun    out  sticky: a completed byte was dropped
//   rx_frame_err  out  one-cycle pulse: stop bit sampled low
//   rx_parity_err out  one-cycle pulse: parity mismatch (parity build only)
//   rx_busy       out  receiving a frame (not in IDLE/ARM)

module uart_rx_unit #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t state, state_next;

  logic              rx_s1, rx_s2, rx_d;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [3:0]        phase;
  logic              samp7, samp8;
  logic              maj;
  logic              decide;
  logic              fall;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              keep_byte;

  logic start_edge, clr_phase, shift_en, load_byte, set_overrun, frame_err_set;
`ifdef UART_RX_PARITY_EN
  logic par_bad, par_capture, par_err_set;
`endif

  assign tick   = (tick_cnt == TICK_LAST);
  assign fall   = rx_d & ~rx_s2;
  assign decide = tick && (phase == 4'd9);
  // Third vote is the live sample taken on the phase-9 tick itself.
  assign maj    = (samp7 & samp8) | (samp7 & rx_s2) | (samp8 & rx_s2);
  assign rx_busy = (state != ST_ARM) && (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign keep_byte = ~par_bad;
`else
  assign keep_byte = 1'b1;
`endif

  // Synchronizer and edge register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= UART_RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Tick generator, realigned to the start edge
  always_ff @(posedge clk) begin
    if (reset || start_edge || tick) tick_cnt <= '0;
    else                             tick_cnt <= tick_cnt + 1'b1;
  end

  // Bit phase; in ARM it doubles as the count of consecutive high ticks
  always_ff @(posedge clk) begin
    if (reset || clr_phase) phase <= '0;
    else if (tick)          phase <= phase + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp7 <= 1'b1;
      samp8 <= 1'b1;
    end else if (tick) begin
      if (phase == 4'd7) samp7 <= rx_s2;
      if (phase == 4'd8) samp8 <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_edge) bit_idx <= '0;
    else if (shift_en)       bit_idx <= bit_idx + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)         shift <= '0;
    else if (shift_en) shift <= {maj, shift[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset || start_edge) par_bad <= 1'b0;
    else if (par_capture)    par_bad <= (^shift) ^ maj;
  end

  always_ff @(posedge clk) begin
    if (reset) rx_parity_err <= 1'b0;
    else       rx_parity_err <= par_err_set;
  end
`endif

  // Holding register and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_set;
      if (load_byte) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (set_overrun)                rx_overrun <= 1'b1;
      else if (rx_valid && rx_ready)  rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARM;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    start_edge    = 1'b0;
    clr_phase     = 1'b0;
    shift_en      = 1'b0;
    load_byte     = 1'b0;
    set_overrun   = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_capture   = 1'b0;
    par_err_set   = 1'b0;
`endif
    unique case (state)
      ST_ARM: begin
        if (!rx_s2)                         clr_phase  = 1'b1;
        else if (tick && phase == 4'd15)    state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (fall) begin
          start_edge = 1'b1;
          clr_phase  = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (decide) begin
          if (maj) begin
            clr_phase  = 1'b1;
            state_next = ST_ARM;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide) begin
          par_capture = 1'b1;
          state_next  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (decide) begin
`ifdef UART_RX_PARITY_EN
          par_err_set = par_bad;
`endif
          if (maj) begin
            state_next = ST_IDLE;
            if (keep_byte) begin
              // A transfer in this same cycle frees the register for the new byte.
              if (!rx_valid || rx_ready) load_byte   = 1'b1;
              else                       set_overrun = 1'b1;
            end
          end else begin
            frame_err_set = 1'b1;
            clr_phase     = 1'b1;
            state_next    = ST_ARM;
          end
        end
      end
      default: state_next = ST_ARM;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
module tb_uart_rx_unit;

  localparam int unsigned CLK_FREQ = 614400;
  localparam int unsigned BAUD     = 9600;
  localparam int TD  = CLK_FREQ / (BAUD * 16);
  localparam int CPB = 16 * TD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
  logic       par_flip = 1'b0;
  int         pe_cycles = 0;
  int         pe_exp = 0;
`endif

  uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .reset        (reset),
    .UART_RX      (UART_RX),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level view of the holding register
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   fe_cycles = 0;
  int   fe_exp = 0;
  logic ready_hold = 1'b1;
  logic m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_overrun = 1'b0;
  int   n_starts = 0;
  int   last_start = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_frame_err) fe_cycles++;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) pe_cycles++;
`endif
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    last_start = cyc;
    n_starts++;
    UART_RX = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      idle(CPB);
    end
`ifdef UART_RX_PARITY_EN
    UART_RX = (^b) ^ par_flip;
    idle(CPB);
`endif
    UART_RX = stop_bit;
    idle(CPB);
    UART_RX = 1'b1;
  endtask

  task automatic xmit(input logic [7:0] b, input logic stop_ok);
    logic good;
    send_frame(b, stop_ok);
    good = stop_ok;
    if (!stop_ok) fe_exp++;
`ifdef UART_RX_PARITY_EN
    if (par_flip) begin
      pe_exp++;
      good = 1'b0;
    end
`endif
    if (good) begin
      if (ready_hold) begin
        exp_q.push_back(b);
        m_data = b;
      end else if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = b;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, ".data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".ovr"}, 32'(rx_overrun), 32'(m_overrun));
    idle(1);
  endtask

  task automatic wait_valid(input int max, output int seen);
    seen = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        seen = cyc;
        break;
      end
    end
  endtask

  initial begin
    int seen;
    int lat;
    int tgt;
    int base;
    logic [7:0] rb;
    logic rok;

    idle(4);
    @(negedge clk);
    check("rst.data", 32'(rx_data), 0);
    check("rst.valid", 32'(rx_valid), 0);
    check("rst.ovr", 32'(rx_overrun), 0);
    check("rst.ferr", 32'(rx_frame_err), 0);
    check("rst.busy", 32'(rx_busy), 0);
    idle(1);
    reset = 1'b0;
    idle(2000);
    @(negedge clk);
    check("idle.busy", 32'(rx_busy), 0);
    check("idle.valid", 32'(rx_valid), 0);
    idle(1);

    // First byte with consumer always ready; also measures decision latency
    rx_ready = 1'b1;
    ready_hold = 1'b1;
    fork
      xmit(8'h54, 1'b1);
      wait_valid(CPB * 12, seen);
    join
    lat = (seen >= 0) ? seen - last_start : 0;
    check("t1.seen", 32'(seen >= 0), 1);
    check("t1.latency_ok", 32'(lat >= 151 * TD && lat <= 155 * TD + 4), 1);
    if (lat < 140 * TD || lat > 170 * TD) lat = 154 * TD + 3;
    check_model("t1");
    check("t1.ferr", 32'(fe_cycles), 32'(fe_exp));

    // Glitch shorter than half a bit must not produce a byte
    UART_RX = 1'b0;
    idle(CPB * 3 / 8);
    UART_RX = 1'b1;
    idle(200);
    @(negedge clk);
    check("glitch.valid", 32'(rx_valid), 0);
    check("glitch.busy", 32'(rx_busy), 0);
    check("glitch.cnt", 32'(got_q.size()), 32'(exp_q.size()));
    idle(1);
    xmit(8'h0C, 1'b1);
    idle(8);
    check_model("glitch.rx");

    // Overrun
    rx_ready = 1'b0;
    ready_hold = 1'b0;
    xmit(8'h54, 1'b1);
    xmit(8'h0C, 1'b1);
    idle(4);
    check_model("ovr");
    pulse_ready();
    check_model("ovr.clr");

    // Ready first asserted on the stop-decision cycle of the second byte
    base = n_starts;
    fork
      begin
        xmit(8'h54, 1'b1);
        xmit(8'h0C, 1'b1);
      end
      begin
        wait (n_starts == base + 2);
        tgt = last_start + lat - 1;
        while (cyc < tgt) idle(1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("sim.v0", 32'(rx_valid), 1);
        check("sim.d0", 32'(rx_data), 'h54);
        idle(1);
        rx_ready = 1'b0;
        exp_q.push_back(8'h54);
        m_valid = 1'b0;
        m_overrun = 1'b0;
        @(negedge clk);
        check("sim.v1", 32'(rx_valid), 1);
        check("sim.d1", 32'(rx_data), 'h0C);
        check("sim.o1", 32'(rx_overrun), 0);
      end
    join
    idle(4);
    check_model("sim");
    pulse_ready();

    // Framing error, then recovery
    rx_ready = 1'b1;
    ready_hold = 1'b1;
    xmit(8'hA5, 1'b0);
    idle(150);
    check("frm.ferr", 32'(fe_cycles), 32'(fe_exp));
    check_model("frm");
    rx_ready = 1'b0;
    ready_hold = 1'b0;
    xmit(8'h3C, 1'b1);
    idle(4);
    check_model("frm.rx");
    xmit(8'h5A, 1'b1);
    idle(4);
    check_model("frm.ovr");

    // Reset during data bit 4
    base = n_starts;
    fork
      send_frame(8'h00, 1'b1);
      begin
        wait (n_starts == base + 1);
        tgt = last_start + 5 * CPB + CPB / 2;
        while (cyc < tgt) idle(1);
        @(negedge clk);
        check("mid.busy", 32'(rx_busy), 1);
        idle(1);
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        check("mid.data", 32'(rx_data), 0);
        check("mid.valid", 32'(rx_valid), 0);
        check("mid.ovr", 32'(rx_overrun), 0);
        check("mid.ferr", 32'(rx_frame_err), 0);
        check("mid.busy0", 32'(rx_busy), 0);
        idle(1);
        reset = 1'b0;
        m_valid = 1'b0;
        m_data = 8'h00;
        m_overrun = 1'b0;
      end
    join
    idle(200);
    check_model("mid.after");
    xmit(8'h84, 1'b1);
    idle(4);
    check_model("mid.rx");
    pulse_ready();

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    xmit(8'h54, 1'b1);
    idle(4);
    check_model("par.bad");
    check("par.perr", 32'(pe_cycles), 32'(pe_exp));
    par_flip = 1'b0;
    xmit(8'h54, 1'b1);
    idle(4);
    check_model("par.good");
    pulse_ready();
`endif

    // Randomized frames against the model
    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 4) == 0);
`endif
      xmit(rb, rok);
      idle(4);
      check_model($sformatf("rnd%0d", k));
      if (!rok) idle(100 + int'($urandom_range(0, 30)));
      else      idle(int'($urandom_range(0, 30)));
      if ($urandom_range(0, 1) == 1) pulse_ready();
    end
    pulse_ready();
    idle(4);

    check("end.count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("end.ferr", 32'(fe_cycles), 32'(fe_exp));
`ifdef UART_RX_PARITY_EN
    check("end.perr", 32'(pe_cycles), 32'(pe_exp));
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
